// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style fetch/decode slice.
package mips_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC selection: jump target, taken-branch target or sequential pc+4.
module next_pc (
  input  logic [31:0] pcplus4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        pcsrc,
  output logic [31:0] pcnext
);

  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Signed word offset; the add wraps naturally at 32 bits.
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pcplus4 + branch_off;
  assign jump_target   = {pcplus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pcnext = pcplus4;
    if (jump)
      pcnext = jump_target;
    else if (pcsrc)
      pcnext = branch_target;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues req/ack reads to instruction memory and holds the word until retire.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  input  logic             jump,
  input  logic             pcsrc,
  input  logic             retire,
  output logic [CNT_W-1:0] retired_cnt
);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg;
  logic [31:0]      instr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      pcplus4_w;
  logic [31:0]      pcnext;
  logic             load_instr;
  logic             do_retire;

  assign pcplus4_w = pc_reg + 32'd4;

  next_pc u_next_pc (
    .pcplus4 (pcplus4_w),
    .instr   (instr_reg),
    .jump    (jump),
    .pcsrc   (pcsrc),
    .pcnext  (pcnext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= S_RESET;
    else
      state_reg <= state_next;
  end

  // Ack outside S_FETCH and retire outside S_EXEC are ignored here.
  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    do_retire   = 1'b0;
    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (retire) begin
          do_retire  = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
      cnt_reg   <= '0;
    end else begin
      if (load_instr)
        instr_reg <= imem_rdata;
      if (do_retire) begin
        pc_reg  <= pcnext;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign pcplus4     = pcplus4_w;
  assign instr       = instr_reg;
  assign op          = instr_reg[31:26];
  assign funct       = instr_reg[5:0];
  assign retired_cnt = cnt_reg;

endmodule
